// File: rtl/instr_encoder.sv
// Program writer for the 8-bit control ISA: encodes one symbolic operation per
// valid/ready handshake and writes the word into instruction memory sequentially.
// Latency: one registered write strobe in the cycle after acceptance. With
// BRANCH_PAD_EN, a branch also writes PAD_WORD in the cycle after that.
// Backpressure: op_ready_o is high only in IDLE, and never in a cycle where
// reset_i or clear_i is asserted.
//
// Optional feature macro: BRANCH_PAD_EN
//   defined   : BRF/BRB occupy two slots, the branch word followed by PAD_WORD
//   undefined : branches occupy one slot, with no PAD cycle
//
// Ports:
//   clk_i, reset_i (sync, active high), clear_i (sync restart, same effect as reset)
//   op_valid_i/op_ready_o handshake; op_code_i, rd_i, rs_i, imm_i operation fields
//   imem_we_o/imem_addr_o/imem_data_o instruction memory write port (registered)
//   count_o words written; done_o sticky after HALT; err_o sticky on illegal/overflow
module instr_encoder #(
    parameter int          ADDR_W   = 8,
    parameter logic [7:0]  PAD_WORD = 8'h00
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              clear_i,
    input  logic              op_valid_i,
    output logic              op_ready_o,
    input  logic [3:0]        op_code_i,
    input  logic [2:0]        rd_i,
    input  logic [2:0]        rs_i,
    input  logic [7:0]        imm_i,
    output logic              imem_we_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    output logic [7:0]        imem_data_o,
    output logic [ADDR_W:0]   count_o,
    output logic              done_o,
    output logic              err_o
);

`ifdef BRANCH_PAD_EN
    localparam bit PAD_EN = 1'b1;
`else
    localparam bit PAD_EN = 1'b0;
`endif

    localparam logic [ADDR_W+1:0] CAPACITY = (ADDR_W+2)'(2**ADDR_W);

    typedef enum logic [1:0] {IDLE, PAD, DONE, ERR} state_t;

    state_t            state_q;
    logic [7:0]        enc_word;
    logic              illegal;
    logic              is_branch;
    logic              is_halt;
    logic [1:0]        need;
    logic [ADDR_W+1:0] need_total;
    logic              accept;

    // Ready drops combinationally while reset/clear is high so a
    // simultaneous op is never taken.
    assign op_ready_o = (state_q == IDLE) & ~reset_i & ~clear_i;
    assign accept     = op_valid_i & op_ready_o;

    always_comb begin
        enc_word  = 8'h00;
        illegal   = 1'b0;
        is_branch = 1'b0;
        is_halt   = 1'b0;
        case (op_code_i)
            4'd0:  enc_word = {2'b00, rd_i, rs_i};
            4'd1:  enc_word = {2'b01, rd_i, rs_i};
            4'd2: begin
                enc_word = {3'b110, imm_i[4:0]};
                illegal  = (imm_i > 8'd31);
            end
            4'd3:  enc_word = {5'b11100, rs_i};
            4'd4:  enc_word = {5'b11101, rs_i};
            4'd5: begin
                enc_word  = {5'b11110, rs_i};
                is_branch = 1'b1;
            end
            4'd6:  enc_word = {5'b11111, rs_i};
            4'd7:  enc_word = 8'b1000_0000;
            4'd8: begin
                enc_word = 8'b1000_1000;
                is_halt  = 1'b1;
            end
            4'd9:  enc_word = {5'b10010, rs_i};
            4'd10: enc_word = {5'b10011, rs_i};
            4'd11: enc_word = {5'b10100, rs_i};
            4'd12: enc_word = {5'b10101, rs_i};
            4'd13: begin
                enc_word  = {5'b10110, rs_i};
                is_branch = 1'b1;
            end
            4'd14: enc_word = {5'b10111, rs_i};
            default: illegal = 1'b1;
        endcase
    end

    // Slots the op needs; checked against remaining capacity so the pointer
    // can reach the last address but never wraps.
    assign need       = (PAD_EN && is_branch) ? 2'd2 : 2'd1;
    assign need_total = {1'b0, count_o} + {{ADDR_W{1'b0}}, need};

    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            state_q     <= IDLE;
            imem_we_o   <= 1'b0;
            imem_addr_o <= '0;
            imem_data_o <= 8'h00;
            count_o     <= '0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
        end else begin
            imem_we_o <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        if (illegal || (need_total > CAPACITY)) begin
                            err_o   <= 1'b1;
                            state_q <= ERR;
                        end else begin
                            imem_we_o   <= 1'b1;
                            imem_addr_o <= count_o[ADDR_W-1:0];
                            imem_data_o <= enc_word;
                            count_o     <= count_o + (ADDR_W+1)'(1);
                            if (is_halt) begin
                                done_o  <= 1'b1;
                                state_q <= DONE;
                            end else if (PAD_EN && is_branch) begin
                                state_q <= PAD;
                            end
                        end
                    end
                end
                PAD: begin
                    // Slot squashed by the decoder after a taken branch.
                    imem_we_o   <= 1'b1;
                    imem_addr_o <= count_o[ADDR_W-1:0];
                    imem_data_o <= PAD_WORD;
                    count_o     <= count_o + (ADDR_W+1)'(1);
                    state_q     <= IDLE;
                end
                default: ; // DONE and ERR hold until reset/clear
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;
    localparam int         AW   = 2;
    localparam int         CAPN = 4;
    localparam logic [7:0] PADW = 8'hA5;
`ifdef BRANCH_PAD_EN
    localparam bit PAD_ON = 1'b1;
`else
    localparam bit PAD_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset_i = 1'b0, clear_i = 1'b0, op_valid_i = 1'b0;
    logic          op_ready_o;
    logic [3:0]    op_code_i = '0;
    logic [2:0]    rd_i = '0, rs_i = '0;
    logic [7:0]    imm_i = '0;
    logic          imem_we_o;
    logic [AW-1:0] imem_addr_o;
    logic [7:0]    imem_data_o;
    logic [AW:0]   count_o;
    logic          done_o, err_o;

    int checks = 0;
    int failures = 0;

    // Reference model: a queue of words waiting to be strobed plus sticky flags.
    logic [7:0] m_q[$];
    int         m_cnt = 0;
    logic       m_done = 0, m_err = 0, m_we = 0;
    logic [7:0] m_data = 0;
    int         m_addr = 0;
    logic       obs_ready, exp_ready;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(AW), .PAD_WORD(PADW)) dut (
        .clk_i(clk), .reset_i(reset_i), .clear_i(clear_i),
        .op_valid_i(op_valid_i), .op_ready_o(op_ready_o),
        .op_code_i(op_code_i), .rd_i(rd_i), .rs_i(rs_i), .imm_i(imm_i),
        .imem_we_o(imem_we_o), .imem_addr_o(imem_addr_o), .imem_data_o(imem_data_o),
        .count_o(count_o), .done_o(done_o), .err_o(err_o)
    );

    function automatic logic [7:0] ref_enc(input int op, input int rd, input int rs, input int imm);
        int pfx[16] = '{0, 0, 0, 28, 29, 30, 31, 16, 17, 18, 19, 20, 21, 22, 23, 0};
        int v;
        if (op == 0)                 v = rd * 8 + rs;
        else if (op == 1)            v = 64 + rd * 8 + rs;
        else if (op == 2)            v = 192 + (imm % 32);
        else if (op == 7 || op == 8) v = pfx[op] * 8;
        else                         v = pfx[op] * 8 + rs;
        return 8'(v);
    endfunction

    // One clock cycle: apply inputs, advance the model at the edge, return at negedge.
    task automatic drive(input logic v, input int op, input int rd, input int rs,
                         input int imm, input logic clr, input logic rst);
        logic acc;
        int   n;
        op_valid_i = v; op_code_i = 4'(op); rd_i = 3'(rd); rs_i = 3'(rs);
        imm_i = 8'(imm); clear_i = clr; reset_i = rst;
        #1;
        obs_ready = op_ready_o;
        exp_ready = !m_done && !m_err && (m_q.size() == 0) && !clr && !rst;
        acc = v && exp_ready;
        @(posedge clk);
        if (clr || rst) begin
            m_q.delete(); m_cnt = 0; m_done = 0; m_err = 0; m_we = 0; m_addr = 0; m_data = 0;
        end else begin
            if (acc) begin
                n = (PAD_ON && (op == 5 || op == 13)) ? 2 : 1;
                if (op == 15 || (op == 2 && imm > 31) || (m_cnt + n > CAPN)) m_err = 1;
                else begin
                    m_q.push_back(ref_enc(op, rd, rs, imm));
                    if (n == 2) m_q.push_back(PADW);
                    if (op == 8) m_done = 1;
                end
            end
            if (m_q.size() > 0) begin
                m_we = 1; m_addr = m_cnt % CAPN; m_data = m_q.pop_front(); m_cnt++;
            end else m_we = 0;
        end
        #1;
        op_valid_i = 0; clear_i = 0; reset_i = 0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0, 0, 1);
        checks++; if (obs_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", obs_ready); end
        checks++; if ({imem_we_o, imem_addr_o, imem_data_o, count_o, done_o, err_o} !== '0) begin
            failures++; $display("FAIL reset_outputs we=%b addr=%0d data=%h cnt=%0d done=%b err=%b exp=all zero",
                                 imem_we_o, imem_addr_o, imem_data_o, count_o, done_o, err_o); end
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++; if (obs_ready !== 1'b1) begin failures++; $display("FAIL reset_ready_after got=%b exp=1", obs_ready); end
    endtask

    task automatic test_add();
        drive(1, 1, 3, 5, 0, 0, 0);
        checks++; if ({imem_we_o, imem_addr_o, imem_data_o} !== {1'b1, 2'd0, 8'h5D}) begin
            failures++; $display("FAIL add_write we=%b addr=%0d data=%h exp=1/0/5d", imem_we_o, imem_addr_o, imem_data_o); end
        checks++; if (count_o !== 3'd1) begin failures++; $display("FAIL add_count got=%0d exp=1", count_o); end
        checks++; if (op_ready_o !== 1'b1) begin failures++; $display("FAIL add_ready got=%b exp=1", op_ready_o); end
    endtask

    task automatic test_set_srl();
        drive(0, 0, 0, 0, 0, 1, 0);
        drive(1, 2, 0, 0, 21, 0, 0);
        checks++; if ({imem_we_o, imem_addr_o, imem_data_o} !== {1'b1, 2'd0, 8'hD5}) begin
            failures++; $display("FAIL set_write we=%b addr=%0d data=%h exp=1/0/d5", imem_we_o, imem_addr_o, imem_data_o); end
        drive(1, 4, 0, 4, 0, 0, 0);
        checks++; if ({imem_we_o, imem_addr_o, imem_data_o, count_o} !== {1'b1, 2'd1, 8'hEC, 3'd2}) begin
            failures++; $display("FAIL srl_write we=%b addr=%0d data=%h cnt=%0d exp=1/1/ec/2", imem_we_o, imem_addr_o, imem_data_o, count_o); end
        drive(1, 2, 0, 0, 40, 0, 0);
        checks++; if ({imem_we_o, err_o, op_ready_o} !== 3'b010) begin
            failures++; $display("FAIL set_range we=%b err=%b rdy=%b exp=0/1/0", imem_we_o, err_o, op_ready_o); end
        drive(1, 1, 1, 1, 0, 0, 0);
        checks++; if ({imem_we_o, count_o, op_ready_o} !== {1'b0, 3'd2, 1'b0}) begin
            failures++; $display("FAIL err_hold we=%b cnt=%0d rdy=%b exp=0/2/0", imem_we_o, count_o, op_ready_o); end
        drive(0, 0, 0, 0, 0, 1, 0);
        checks++; if ({err_o, count_o, op_ready_o} !== {1'b0, 3'd0, 1'b1}) begin
            failures++; $display("FAIL err_clear err=%b cnt=%0d rdy=%b exp=0/0/1", err_o, count_o, op_ready_o); end
    endtask

    task automatic test_branch();
        drive(0, 0, 0, 0, 0, 1, 0);
        drive(1, 0, 1, 2, 0, 0, 0);
        drive(1, 5, 0, 2, 0, 0, 0);
        checks++; if ({imem_we_o, imem_addr_o, imem_data_o} !== {1'b1, 2'd1, 8'hF2}) begin
            failures++; $display("FAIL brf_write we=%b addr=%0d data=%h exp=1/1/f2", imem_we_o, imem_addr_o, imem_data_o); end
        checks++; if (op_ready_o !== !PAD_ON) begin failures++; $display("FAIL brf_ready got=%b exp=%b", op_ready_o, !PAD_ON); end
        drive(0, 0, 0, 0, 0, 0, 0);
        if (PAD_ON) begin
            checks++; if ({imem_we_o, imem_addr_o, imem_data_o, count_o} !== {1'b1, 2'd2, PADW, 3'd3}) begin
                failures++; $display("FAIL pad_write we=%b addr=%0d data=%h cnt=%0d exp=1/2/a5/3", imem_we_o, imem_addr_o, imem_data_o, count_o); end
        end else begin
            checks++; if ({imem_we_o, count_o} !== {1'b0, 3'd2}) begin
                failures++; $display("FAIL nopad we=%b cnt=%0d exp=0/2", imem_we_o, count_o); end
        end
    endtask

    task automatic test_halt();
        drive(0, 0, 0, 0, 0, 1, 0);
        drive(1, 0, 1, 1, 0, 0, 0);
        drive(1, 9, 0, 3, 0, 0, 0);
        drive(1, 12, 0, 6, 0, 0, 0);
        drive(1, 8, 0, 5, 0, 0, 0);
        checks++; if ({imem_we_o, imem_addr_o, imem_data_o, count_o, done_o, op_ready_o} !== {1'b1, 2'd3, 8'h88, 3'd4, 1'b1, 1'b0}) begin
            failures++; $display("FAIL halt_write we=%b addr=%0d data=%h cnt=%0d done=%b rdy=%b exp=1/3/88/4/1/0",
                                 imem_we_o, imem_addr_o, imem_data_o, count_o, done_o, op_ready_o); end
        drive(1, 1, 2, 2, 0, 0, 0);
        checks++; if ({imem_we_o, count_o, done_o, err_o} !== {1'b0, 3'd4, 1'b1, 1'b0}) begin
            failures++; $display("FAIL halt_ignore we=%b cnt=%0d done=%b err=%b exp=0/4/1/0", imem_we_o, count_o, done_o, err_o); end
        drive(0, 0, 0, 0, 0, 1, 0);
        checks++; if ({count_o, done_o, op_ready_o} !== {3'd0, 1'b0, 1'b1}) begin
            failures++; $display("FAIL halt_clear cnt=%0d done=%b rdy=%b exp=0/0/1", count_o, done_o, op_ready_o); end
    endtask

    task automatic test_capacity();
        drive(0, 0, 0, 0, 0, 1, 0);
        drive(1, 3, 0, 1, 0, 0, 0);
        drive(1, 6, 0, 2, 0, 0, 0);
        drive(1, 7, 0, 3, 0, 0, 0);
        drive(1, 14, 0, 7, 0, 0, 0);
        checks++; if ({imem_we_o, imem_addr_o, imem_data_o, count_o} !== {1'b1, 2'd3, 8'hBF, 3'd4}) begin
            failures++; $display("FAIL cap_last we=%b addr=%0d data=%h cnt=%0d exp=1/3/bf/4", imem_we_o, imem_addr_o, imem_data_o, count_o); end
        drive(1, 11, 0, 0, 0, 0, 0);
        checks++; if ({imem_we_o, err_o, count_o} !== {1'b0, 1'b1, 3'd4}) begin
            failures++; $display("FAIL cap_over we=%b err=%b cnt=%0d exp=0/1/4", imem_we_o, err_o, count_o); end
        drive(0, 0, 0, 0, 0, 1, 0);
        drive(1, 3, 0, 1, 0, 0, 0);
        drive(1, 3, 0, 1, 0, 0, 0);
        drive(1, 3, 0, 1, 0, 0, 0);
        drive(1, 13, 0, 1, 0, 0, 0);
        checks++; if ({imem_we_o, err_o, count_o} !== {PAD_ON ? 1'b0 : 1'b1, PAD_ON, 3'(PAD_ON ? 3 : 4)}) begin
            failures++; $display("FAIL cap_branch we=%b err=%b cnt=%0d exp=%b/%b/%0d", imem_we_o, err_o, count_o,
                                 !PAD_ON, PAD_ON, PAD_ON ? 3 : 4); end
    endtask

    task automatic test_reset_mid();
        drive(0, 0, 0, 0, 0, 1, 0);
        drive(1, 5, 0, 4, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 1);
        checks++; if ({imem_we_o, imem_addr_o, imem_data_o, count_o, done_o, err_o} !== '0) begin
            failures++; $display("FAIL reset_mid we=%b addr=%0d data=%h cnt=%0d done=%b err=%b exp=all zero",
                                 imem_we_o, imem_addr_o, imem_data_o, count_o, done_o, err_o); end
        drive(1, 1, 1, 1, 0, 1, 0);
        checks++; if (obs_ready !== 1'b0) begin failures++; $display("FAIL clear_vs_op_ready got=%b exp=0", obs_ready); end
        drive(0, 0, 0, 0, 0, 0, 0);
        checks++; if ({imem_we_o, count_o} !== {1'b0, 3'd0}) begin
            failures++; $display("FAIL clear_vs_op we=%b cnt=%0d exp=0/0", imem_we_o, count_o); end
    endtask

    task automatic test_random();
        int op, r;
        for (int i = 0; i < 600; i++) begin
            r  = $urandom_range(0, 99);
            op = ($urandom_range(0, 9) == 0) ? $urandom_range(13, 15) : $urandom_range(0, 14);
            drive($urandom_range(0, 3) != 0, op, $urandom_range(0, 7), $urandom_range(0, 7),
                  ($urandom_range(0, 5) == 0) ? $urandom_range(32, 255) : $urandom_range(0, 31),
                  r < 12, r >= 97);
            checks++; if (obs_ready !== exp_ready) begin failures++; $display("FAIL rnd_ready i=%0d got=%b exp=%b", i, obs_ready, exp_ready); end
            checks++; if (imem_we_o !== m_we) begin failures++; $display("FAIL rnd_we i=%0d got=%b exp=%b", i, imem_we_o, m_we); end
            checks++; if ({imem_addr_o, imem_data_o} !== {2'(m_addr), m_data}) begin
                failures++; $display("FAIL rnd_word i=%0d got=%0d/%h exp=%0d/%h", i, imem_addr_o, imem_data_o, m_addr, m_data); end
            checks++; if ({count_o, done_o, err_o} !== {3'(m_cnt), m_done, m_err}) begin
                failures++; $display("FAIL rnd_status i=%0d got=%0d/%b/%b exp=%0d/%b/%b", i, count_o, done_o, err_o, m_cnt, m_done, m_err); end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_set_srl();
        test_branch();
        test_halt();
        test_capacity();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
Program writer for the 8-bit control ISA. It accepts one symbolic operation at a time (op code, register fields, immediate) over a valid/ready handshake. It encodes each operation into the 8-bit instruction word the control decoder consumes, and writes that word sequentially into instruction memory. It sits between the host/bootstrap loader and the instruction memory write port, and tracks program length, halt termination and overflow.

Parameters:
ADDR_W, 8, instruction memory address width; capacity = 2^ADDR_W words
PAD_WORD, 8'h00, word inserted after branches when BRANCH_PAD_EN is defined

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
clear_i  in  1  synchronous restart: address/count/flags to 0, state IDLE (same effect as reset_i)
op_valid_i  in  1  operation present
op_ready_o  out  1  encoder can accept an operation this cycle
op_code_i  in  4  0 AND,1 ADD,2 SET,3 SLL,4 SRL,5 BRF,6 SUBS,7 SLT,8 HALT,9 LOAD,10 STORE,11 ABS,12 SEQ,13 BRB,14 ADDC,15 illegal
rd_i  in  3  destination field (AND/ADD only)
rs_i  in  3  register field
imm_i  in  8  immediate (SET only; legal range 0..31)
imem_we_o  out  1  instruction memory write strobe
imem_addr_o  out  ADDR_W  write address
imem_data_o  out  8  encoded instruction
count_o  out  ADDR_W+1  words written since reset/clear
done_o  out  1  HALT written; sticky until reset/clear
err_o  out  1  illegal op, out-of-range immediate or overflow; sticky until reset/clear

Behaviour:
- Encoding (bits [7:0]):
  - AND = 00,rd,rs
  - ADD = 01,rd,rs
  - SET = 110,imm[4:0]
  - SLL = 11100,rs
  - SRL = 11101,rs
  - BRF = 11110,rs
  - SUBS = 11111,rs
  - SLT = 10000,000
  - HALT = 10001,000
  - LOAD = 10010,rs
  - STORE = 10011,rs
  - ABS = 10100,rs
  - SEQ = 10101,rs
  - BRB = 10110,rs
  - ADDC = 10111,rs
- Unused fields are ignored.
- States: IDLE, PAD, DONE, ERR.
- Reset/clear values: state IDLE; imem_we_o 0, imem_addr_o 0, imem_data_o 0, count_o 0, done_o 0, err_o 0.
- op_ready_o is 1 only in IDLE, and is 0 in the cycle reset_i/clear_i is high.
- Acceptance: an operation is accepted at the rising edge where op_valid_i & op_ready_o.
- Latency: imem_we_o is high for exactly the cycle after acceptance. imem_addr_o shows the current write pointer; imem_data_o shows the encoded word (registered outputs).
- The write pointer and count_o increment after each write.
- imem_addr_o/imem_data_o hold their last values when imem_we_o is 0.
- HALT: word written, then state DONE. done_o = 1 from the write cycle onward; ready stays 0.
- Illegal op (15), or SET with imm_i > 31: no write; err_o = 1 next cycle; state ERR (ready 0).
- Capacity: an op needing N words is accepted only if at least N slots remain (count_o + N <= 2^ADDR_W). Otherwise it is consumed, nothing is written, and the block goes to ERR.
- A word written to the last address (2^ADDR_W - 1) is legal; the pointer never wraps silently.
- reset_i/clear_i mid-operation (including during PAD) abandon any pending write: no strobe in the following cycle.
- clear_i and op_valid_i in the same cycle: clear wins, the op is not accepted.
- ERR and DONE are exited only by reset_i/clear_i.

Optional Feature:
BRANCH_PAD_EN:
- Defined: each BRF/BRB needs 2 slots. The branch word is written, the FSM enters PAD, and PAD_WORD is written in the next cycle (two consecutive strobe cycles, addresses A and A+1). The block then returns to IDLE. This fills the slot the decoder squashes after a taken branch.
- Undefined: branches use 1 slot with no PAD state, and software schedules the slot after each branch.

Test Plan:
- Reset, then ADD rd=3 rs=5 -> one strobe, addr 0, data 8'h5D, count_o 1, ready high again next cycle.
- SET imm=21, then SRL rs=4, back-to-back -> data 8'hD5 at addr 0, then 8'hEC at addr 1; SET imm=40 -> no strobe, err_o 1, ready 0 until clear_i.
- BRF rs=2 with BRANCH_PAD_EN -> 8'hF2 at addr A, PAD_WORD at A+1, ready low during PAD; without the macro -> single strobe.
- HALT after 3 words -> 8'h88 at addr 3, done_o 1, count_o 4, further op_valid_i ignored; clear_i -> count_o 0, done_o 0, ready 1.
- ADDR_W=2: write 4 ops (last at addr 3), then a 5th -> no strobe, err_o 1; with BRANCH_PAD_EN, a branch when 1 slot is left -> rejected, err_o 1.
- Assert reset_i in the acceptance cycle's successor -> no strobe, all outputs at reset values.
